// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: FWFT word FIFO behind the UART receiver, with overrun
// detection, idle-line character timeout and a registered interrupt.
module uart_rx_ctrl #(
  parameter int unsigned DBITS    = 8,
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned TO_TICKS = 640,
  parameter int unsigned TO_W     = 10
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               rx_enable,
  input  logic               rx_data_ready,
  input  logic [DBITS-1:0]   rx_data,
  input  logic               sample_tick,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [DBITS-1:0]   rd_data,
  output logic [FIFO_AW:0]   fifo_count,
  input  logic [FIFO_AW:0]   irq_threshold,
  input  logic               clr_overrun,
  output logic               overrun,
  output logic               timeout,
  output logic               irq
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {T_EMPTY, T_ARMED, T_EXPIRED} tstate_e;

  logic [DBITS-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               rd_valid_q, rd_valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               irq_q, irq_d;
  logic [TO_W-1:0]    tcnt_q, tcnt_d;
  tstate_e            state_q, state_d;

  logic push_c, pop_c, full_c, wr_en_c, drop_c, going_empty_c;

  assign push_c        = rx_data_ready & rx_enable;
  assign pop_c         = rd_valid_q & rd_ready;
  assign full_c        = (count_q == CW'(DEPTH));
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_en_c       = push_c & (~full_c | pop_c);
  assign drop_c        = push_c & full_c & ~pop_c;
  assign going_empty_c = pop_c & ~wr_en_c & (count_q == CW'(1));

  // Storage: not reset, written only on accepted pushes.
  always_ff @(posedge clk_100MHz) begin
    if (wr_en_c) mem[wr_ptr_q] <= rx_data;
  end

  assign rd_data = mem[rd_ptr_q];

  // FIFO bookkeeping, overrun and interrupt next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rd_valid_d = (count_d != '0);
    overrun_d  = drop_c | (overrun_q & ~clr_overrun);
    irq_d      = overrun_q | timeout_q |
                 ((irq_threshold != '0) && (count_q >= irq_threshold));
  end

  // Character-timeout FSM; draining the FIFO overrides every state.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    if (going_empty_c) begin
      state_d   = T_EMPTY;
      tcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        T_EMPTY: begin
          tcnt_d    = '0;
          timeout_d = 1'b0;
          if (push_c) state_d = T_ARMED;
        end
        T_ARMED: begin
          if (push_c || pop_c) begin
            tcnt_d = '0;
          end else if (sample_tick) begin
            if (tcnt_q == TO_W'(TO_TICKS - 1)) begin
              state_d   = T_EXPIRED;
              timeout_d = 1'b1;
            end else begin
              tcnt_d = tcnt_q + TO_W'(1);
            end
          end
        end
        T_EXPIRED: begin
          if (push_c || pop_c) begin
            state_d   = T_ARMED;
            tcnt_d    = '0;
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d   = T_EMPTY;
          tcnt_d    = '0;
          timeout_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      irq_q      <= 1'b0;
      tcnt_q     <= '0;
      state_q    <= T_EMPTY;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      irq_q      <= irq_d;
      tcnt_q     <= tcnt_d;
      state_q    <= state_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed and random traffic checked every cycle
// against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int unsigned DBITS    = 8;
  localparam int unsigned FIFO_AW  = 4;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned TO_TICKS = 640;
  localparam int unsigned TO_W     = 10;

  logic               clk_100MHz = 1'b0;
  logic               reset;
  logic               rx_enable;
  logic               rx_data_ready;
  logic [DBITS-1:0]   rx_data;
  logic               sample_tick;
  logic               rd_ready;
  logic               rd_valid;
  logic [DBITS-1:0]   rd_data;
  logic [FIFO_AW:0]   fifo_count;
  logic [FIFO_AW:0]   irq_threshold;
  logic               clr_overrun;
  logic               overrun;
  logic               timeout;
  logic               irq;

  always #5 clk_100MHz = ~clk_100MHz;

  uart_rx_ctrl #(
    .DBITS(DBITS), .FIFO_AW(FIFO_AW), .TO_TICKS(TO_TICKS), .TO_W(TO_W)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .rx_enable(rx_enable),
    .rx_data_ready(rx_data_ready), .rx_data(rx_data), .sample_tick(sample_tick),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_count(fifo_count), .irq_threshold(irq_threshold),
    .clr_overrun(clr_overrun), .overrun(overrun), .timeout(timeout), .irq(irq)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queue contents, sticky flags, idle ticks since activity.
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit m_ovr, m_to, m_irq;
  int m_idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 0; m_to = 0; m_irq = 0; m_idle = 0;
  endtask

  task automatic check_outputs();
    chk("rd_valid",   32'(rd_valid),   32'(mq.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("timeout",    32'(timeout),    32'(m_to));
    chk("irq",        32'(irq),        32'(m_irq));
    if (mq.size() != 0) chk("rd_data_head", 32'(rd_data), 32'(mq[0]));
  endtask

  // One clock cycle of stimulus; model advanced from the pre-edge values.
  task automatic cyc(input bit push, input logic [7:0] d, input bit rdy,
                     input bit tick, input bit clr);
    bit pe, pop, full, acc, drop, irq_n;
    rx_data_ready = push; rx_data = d; rd_ready = rdy;
    sample_tick = tick; clr_overrun = clr;
    #1;
    pe   = push && rx_enable;
    pop  = rdy && (mq.size() != 0);
    full = (mq.size() == DEPTH);
    acc  = pe && (!full || pop);
    drop = pe && full && !pop;
    irq_n = m_ovr || m_to ||
            ((irq_threshold != 0) && (mq.size() >= int'(irq_threshold)));
    if (pop) begin
      chk("rd_data_pop", 32'(rd_data), 32'(mq[0]));
      got.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (acc) mq.push_back(d);
    m_ovr = drop || (m_ovr && !clr);
    if (mq.size() == 0 || pe || pop) begin
      m_idle = 0;
      m_to   = 0;
    end else if (tick && !m_to) begin
      m_idle++;
      if (m_idle == TO_TICKS) m_to = 1;
    end
    m_irq = irq_n;
    @(posedge clk_100MHz); #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; rx_enable = 1'b1; rx_data_ready = 1'b0; rx_data = '0;
    sample_tick = 1'b0; rd_ready = 1'b0; irq_threshold = '0; clr_overrun = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk_100MHz); #1;
    reset = 1'b0;
    check_outputs();

    // Two words, then drain.
    cyc(1, 8'hA5, 0, 0, 0);
    chk("first_valid", 32'(rd_valid), 32'd1);
    chk("first_head",  32'(rd_data),  32'hA5);
    cyc(1, 8'h3C, 0, 0, 0);
    chk("count_two",   32'(fifo_count), 32'd2);
    got.delete();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("pop0", 32'(got[0]), 32'hA5);
    chk("pop1", 32'(got[1]), 32'h3C);
    chk("drained_valid", 32'(rd_valid), 32'd0);

    // Fill, overflow, drain in order, clear overrun.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
    cyc(1, 8'hFF, 0, 0, 0);
    chk("ovr_set", 32'(overrun), 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("ovr_irq", 32'(irq), 32'd1);
    got.delete();
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) chk("drain_order", 32'(got[i]), 32'(i));
    cyc(0, 0, 0, 0, 1);
    chk("ovr_clr", 32'(overrun), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("irq_clr", 32'(irq), 32'd0);

    // Full with simultaneous push/pop, then pointer wrap.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
    cyc(1, 8'h77, 1, 0, 0);
    chk("full_pp_ovr",   32'(overrun),    32'd0);
    chk("full_pp_count", 32'(fifo_count), 32'd16);
    got.delete();
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);
    chk("last_is_77", 32'(got[15]), 32'h77);
    for (int i = 0; i < 40; i++) cyc(1, 8'(8'h80 + i), (i % 3) != 0, 0, 0);
    while (mq.size() != 0) cyc(0, 0, 1, 0, 0);

    // Character timeout on exactly the 640th tick.
    cyc(1, 8'h11, 0, 0, 0);
    for (int t = 1; t <= int'(TO_TICKS); t++) begin
      repeat (15) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      if (t == int'(TO_TICKS) - 1) chk("to_before", 32'(timeout), 32'd0);
    end
    chk("to_set", 32'(timeout), 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("to_irq", 32'(irq), 32'd1);
    cyc(0, 0, 1, 0, 0);
    chk("to_clr", 32'(timeout), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("to_irq_clr", 32'(irq), 32'd0);

    // Threshold interrupt, then discarded words while disabled.
    irq_threshold = 5'd4;
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
    chk("thr_not_yet", 32'(irq), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("thr_rise", 32'(irq), 32'd1);
    cyc(0, 0, 1, 0, 0);
    chk("thr_count3", 32'(fifo_count), 32'd3);
    cyc(0, 0, 0, 0, 0);
    chk("thr_fall", 32'(irq), 32'd0);
    while (mq.size() != 0) cyc(0, 0, 1, 0, 0);
    irq_threshold = 5'd20;
    rx_enable = 1'b0;
    for (int i = 0; i < 20; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("dis_count", 32'(fifo_count), 32'd0);
    chk("dis_ovr",   32'(overrun),    32'd0);
    rx_enable = 1'b1;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) irq_threshold = 5'($urandom_range(0, 20));
      rx_enable = ($urandom % 10) != 0;
      cyc(($urandom % 2) == 1, 8'($urandom), ($urandom % 3) == 0,
          ($urandom % 4) == 0, ($urandom % 16) == 0);
    end
    rx_enable = 1'b1;
    irq_threshold = '0;

    // Asynchronous reset mid-fill with the timeout armed.
    while (mq.size() != 0) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    @(posedge clk_100MHz); #1;
    reset = 1'b0;
    cyc(1, 8'h5A, 0, 0, 0);
    chk("post_rst_head", 32'(rd_data), 32'h5A);
    chk("post_rst_cnt",  32'(fifo_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller between the UART receiver and the bus/consumer logic. It captures each completed receiver word into a first-word-fall-through FIFO. It presents the words on a valid/ready read port and detects overrun. It raises an interrupt on a fill threshold or on an idle-line character timeout, with the timeout measured in baud sample ticks.

Parameters:
DBITS, 8, data word width; matches the receiver word width.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16).
TO_TICKS, 640, sample ticks without FIFO activity before timeout (40 bit times at 16x oversampling); must be >= 2.
TO_W, 10, timeout counter width; 2**TO_W must be > TO_TICKS.

Ports:
clk_100MHz  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
rx_enable  in  1  1 = accept receiver words; 0 = discard them silently.
rx_data_ready  in  1  one-cycle pulse from the receiver: word complete.
rx_data  in  DBITS  receiver word; valid in the cycle rx_data_ready = 1.
sample_tick  in  1  baud-rate sample tick (16x oversampling).
rd_ready  in  1  consumer accepts rd_data this cycle.
rd_valid  out  1  FIFO non-empty.
rd_data  out  DBITS  FIFO head word (FWFT); don't-care when rd_valid = 0.
fifo_count  out  FIFO_AW+1  number of words held, 0..2**FIFO_AW.
irq_threshold  in  FIFO_AW+1  fill-level interrupt threshold; 0 disables the threshold source.
clr_overrun  in  1  one-cycle pulse; clears the overrun flag.
overrun  out  1  sticky: a word was dropped because the FIFO was full.
timeout  out  1  sticky: character timeout expired.
irq  out  1  registered OR of the enabled interrupt sources.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - pointers = 0, fifo_count = 0, rd_valid = 0.
  - overrun = 0, timeout = 0, irq = 0.
  - timeout FSM enters T_EMPTY; tick counter = 0.
  - FIFO memory contents are not reset.
- push = rx_data_ready & rx_enable. pop = rd_valid & rd_ready.
- Push when not full: rx_data is written at wr_ptr and wr_ptr increments, wrapping modulo 2**FIFO_AW. The word is visible on rd_data/rd_valid on the next cycle (1-cycle latency).
- Push when full and no pop: the word is dropped and overrun is set from the next cycle.
- Push when full with a simultaneous pop: the push is accepted, no overrun is flagged, and fifo_count is unchanged.
- rx_data_ready while rx_enable = 0: the word is discarded and overrun is not affected.
- Pop: rd_ptr increments (wraps). rd_data is combinational from mem[rd_ptr].
- Push and pop together when not full or empty: fifo_count is unchanged and both pointers advance.
- Push to an empty FIFO: no pop can occur that cycle (rd_valid = 0).
- fifo_count updates registered: +1 on push only, -1 on pop only.
- overrun:
  - Set on a dropped word; cleared by clr_overrun.
  - A set event and clr_overrun in the same cycle: set wins.
- Timeout FSM (tick counter tcnt, TO_W bits):
  - T_EMPTY: tcnt = 0. A push moves to T_ARMED.
  - T_ARMED: tcnt = 0 on any push or pop. Otherwise a sample_tick increments tcnt. If sample_tick arrives while tcnt == TO_TICKS-1, go to T_EXPIRED and set timeout.
  - T_EXPIRED: tcnt holds and timeout = 1. A push or pop clears timeout, sets tcnt = 0 and moves to T_ARMED.
  - From any state: if the FIFO becomes empty (pop of the last word with no push), go to T_EMPTY, set tcnt = 0 and clear timeout.
  - A push and the expiry tick in the same cycle: the push wins (stay in T_ARMED, tcnt = 0).
- irq is registered, updating one cycle after its sources change:
  - irq = overrun | timeout | (irq_threshold != 0 & fifo_count >= irq_threshold).
  - irq_threshold greater than the depth: the threshold source never fires.

Test Plan:
- Push 0xA5, 0x3C with rd_ready = 0 -> rd_valid = 1 one cycle after the first push; rd_data = 0xA5; fifo_count = 2. Then rd_ready = 1 for 2 cycles -> rd_data 0xA5 then 0x3C, rd_valid = 0, fifo_count = 0.
- Fill 16 words 0x00..0x0F, push 0xFF -> 0xFF dropped, overrun = 1, irq = 1. Drain -> 0x00..0x0F in order. clr_overrun -> overrun = 0 and irq = 0 (threshold 0).
- FIFO full, push 0x77 with simultaneous pop -> overrun stays 0, fifo_count = 16, 0x77 is read last. Then run pointer wrap over 40 pushes/pops -> data order preserved.
- One word held, sample_tick every 16 cycles, no activity -> timeout = 1 exactly on the 640th tick; irq = 1 the next cycle. A pop -> timeout = 0, FSM T_EMPTY.
- irq_threshold = 4 -> irq rises the cycle after fifo_count reaches 4 and falls after fifo_count drops to 3. With rx_enable = 0, 20 pulses -> fifo_count = 0, overrun = 0.
- Assert reset mid-fill (5 words, timeout armed) -> all outputs 0 immediately, asynchronously. After release, the first push appears as the head word.
